// File: rtl/wb_obi_bridge_pkg.sv
// Shared types and default geometry for the inbound Wishbone-to-OBI bridge.
package wb_obi_bridge_pkg;

    // Transfer sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } wb_obi_state_e;

    localparam int unsigned DEF_ADDR_WIDTH     = 32;
    localparam int unsigned DEF_DATA_WIDTH     = 32;
    localparam int unsigned DEF_RAM_ADDR_WIDTH = 14;
    localparam logic [31:0] DEF_BASE_ADDR      = 32'h0200_0000;

    // Lowest address bit that takes part in the window decode (word address + byte offset)
    function automatic int unsigned win_lsb(input int unsigned ram_addr_width);
        return ram_addr_width + 2;
    endfunction

    // Window-compare bit range for the default geometry
    localparam int unsigned WIN_LSB = win_lsb(DEF_RAM_ADDR_WIDTH);
    localparam int unsigned WIN_MSB = DEF_ADDR_WIDTH - 1;

endpackage

// File: rtl/wb_obi_bridge.sv
// Wishbone classic slave to OBI master bridge into the core data RAM window.
// One transfer at a time; out-of-window accesses are answered with wb_err_o.
module wb_obi_bridge
    import wb_obi_bridge_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int unsigned           DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int unsigned           RAM_ADDR_WIDTH = DEF_RAM_ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = ADDR_WIDTH'(DEF_BASE_ADDR)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    wb_cyc_i,
    input  logic                    wb_stb_i,
    input  logic                    wb_we_i,
    input  logic [DATA_WIDTH/8-1:0] wb_sel_i,
    input  logic [ADDR_WIDTH-1:0]   wb_adr_i,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    output logic                    wb_ack_o,
    output logic                    wb_err_o,
    output logic                    obi_req_o,
    input  logic                    obi_gnt_i,
    output logic [ADDR_WIDTH-1:0]   obi_addr_o,
    output logic                    obi_we_o,
    output logic [DATA_WIDTH/8-1:0] obi_be_o,
    output logic [DATA_WIDTH-1:0]   obi_wdata_o,
    input  logic                    obi_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   obi_rdata_i
);

    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned WIN_LO   = win_lsb(RAM_ADDR_WIDTH);
    localparam int unsigned WIN_HI   = ADDR_WIDTH - 1;
    localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(3);

    // Unsigned compare of the address bits above the RAM window against the base
    function automatic logic in_window(input logic [ADDR_WIDTH-1:0] adr);
        return adr[WIN_HI:WIN_LO] == BASE_ADDR[WIN_HI:WIN_LO];
    endfunction

    wb_obi_state_e           state_q, state_d;
    logic                    abort_q, abort_d;
    logic                    req_q,   req_d;
    logic [ADDR_WIDTH-1:0]   addr_q,  addr_d;
    logic                    we_q,    we_d;
    logic [BE_WIDTH-1:0]     be_q,    be_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    ack_q,   ack_d;
    logic                    err_q,   err_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

    // Next-state and registered-output logic for the transfer sequencer
    always_comb begin
        state_d = state_q;
        abort_d = abort_q;
        req_d   = req_q;
        addr_d  = addr_q;
        we_d    = we_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        rdata_d = rdata_q;

        case (state_q)
            IDLE: begin
                abort_d = 1'b0;
                if (wb_cyc_i && wb_stb_i) begin
                    if (in_window(wb_adr_i)) begin
                        addr_d  = wb_adr_i & WORD_MASK;
                        we_d    = wb_we_i;
                        be_d    = wb_sel_i;
                        wdata_d = wb_dat_i;
                        req_d   = 1'b1;
                        state_d = REQ;
                    end else begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end

            REQ: begin
                // A dropped cycle is remembered, but the request is never retracted
                if (!wb_cyc_i) begin
                    abort_d = 1'b1;
                end
                if (obi_gnt_i) begin
                    req_d   = 1'b0;
                    state_d = RESP;
                end
            end

            RESP: begin
                if (!wb_cyc_i) begin
                    abort_d = 1'b1;
                end
                if (obi_rvalid_i) begin
                    if (!we_q) begin
                        rdata_d = obi_rdata_i;
                    end
                    if (abort_q || !wb_cyc_i) begin
                        state_d = IDLE;
                    end else begin
                        ack_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            abort_q <= 1'b0;
            req_q   <= 1'b0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            abort_q <= abort_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign obi_req_o   = req_q;
    assign obi_addr_o  = addr_q;
    assign obi_we_o    = we_q;
    assign obi_be_o    = be_q;
    assign obi_wdata_o = wdata_q;
    assign wb_ack_o    = ack_q;
    assign wb_err_o    = err_q;
    assign wb_dat_o    = rdata_q;

endmodule
